// File: rtl/img2col_patch_reader_if.sv
// Tensor-RAM port A plus patch-stream bundle for img2col_patch_reader.
//   ram_ena/ram_wea/ram_addr : read issue toward the tensor RAM
//   ram_dout                 : RAM read data, valid one cycle after ram_ena
//   m_data/m_valid/m_ready   : patch element stream toward the GEMM feeder
//   m_col_last/m_frame_last  : end-of-column / end-of-frame markers on m_data
// master = patch reader side, slave = RAM model + stream consumer side.
interface img2col_patch_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 12
);
  logic                  ram_ena;
  logic                  ram_wea;
  logic [ADDR_SIZE-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_col_last;
  logic                  m_frame_last;

  modport master (
    output ram_ena, ram_wea, ram_addr,
    input  ram_dout,
    output m_data, m_valid, m_col_last, m_frame_last,
    input  m_ready
  );

  modport slave (
    input  ram_ena, ram_wea, ram_addr,
    output ram_dout,
    input  m_data, m_valid, m_col_last, m_frame_last,
    output m_ready
  );
endinterface

// File: rtl/img2col_patch_reader.sv
// Img2col front end: walks a CHW tensor in tensor RAM and streams the unrolled
// patch matrix, one column of CH*K*K elements per output pixel (kx innermost,
// then ky, c, ox, oy). Pad positions are produced as zero without a RAM read.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : one-cycle pulse, begins a tensor when idle
//   busy        : high while the frame is being read/drained
//   done        : one-cycle pulse after the final element handshake
//   bus         : RAM read port and valid/ready patch stream (master modport)
module img2col_patch_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 12,
  parameter int IMG_H      = 8,
  parameter int IMG_W      = 8,
  parameter int CH         = 3,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  img2col_patch_reader_if.master bus
);

  localparam int OH = (IMG_H + 2*PAD - K) / STRIDE + 1;
  localparam int OW = (IMG_W + 2*PAD - K) / STRIDE + 1;
  localparam int CW = 16;

  localparam logic [CW-1:0] K_MAX  = CW'(K - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(CH - 1);
  localparam logic [CW-1:0] OX_MAX = CW'(OW - 1);
  localparam logic [CW-1:0] OY_MAX = CW'(OH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0] kx, ky, c, ox, oy;
  logic signed [31:0] iy, ix;
  logic in_bounds, col_last, frame_last;
  logic issue, push, pop;

  // Tag pipe: one stage matching the RAM read latency.
  logic inflight, tag_pad, tag_col, tag_frm;

  // Two-entry output FIFO.
  logic [DATA_WIDTH-1:0] fifo_d  [2];
  logic                  fifo_cl [2];
  logic                  fifo_fl [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] push_data;

  // Position decode for the element at the current counters.
  always_comb begin
    iy = $signed(32'(oy)) * STRIDE + $signed(32'(ky)) - PAD;
    ix = $signed(32'(ox)) * STRIDE + $signed(32'(kx)) - PAD;
    in_bounds  = (iy >= 0) && (iy < IMG_H) && (ix >= 0) && (ix < IMG_W);
    col_last   = (kx == K_MAX) && (ky == K_MAX) && (c == C_MAX);
    frame_last = col_last && (ox == OX_MAX) && (oy == OY_MAX);
  end

  assign pop  = (count != 2'd0) && bus.m_ready;
  assign push = inflight;

  // A pop in this cycle frees a slot, so it counts as credit; this keeps one
  // element per cycle flowing while the FIFO occupancy plus the in-flight read
  // never exceeds two.
  assign issue = (state == S_RUN) &&
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign bus.ram_ena  = issue && in_bounds;
  assign bus.ram_wea  = 1'b0;
  assign bus.ram_addr = bus.ram_ena
                      ? ADDR_SIZE'(($signed(32'(c)) * IMG_H + iy) * IMG_W + ix)
                      : '0;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (issue && frame_last) state_nx = S_DRAIN;
      // Leave as the last element is being popped so done follows it directly.
      S_DRAIN: if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop)))
                 state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Element counters, kx innermost. A full frame wraps all of them back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0; ky <= '0; c <= '0; ox <= '0; oy <= '0;
    end else if ((state == S_IDLE) && start) begin
      kx <= '0; ky <= '0; c <= '0; ox <= '0; oy <= '0;
    end else if (issue) begin
      if (kx != K_MAX) begin
        kx <= kx + 1'b1;
      end else begin
        kx <= '0;
        if (ky != K_MAX) begin
          ky <= ky + 1'b1;
        end else begin
          ky <= '0;
          if (c != C_MAX) begin
            c <= c + 1'b1;
          end else begin
            c <= '0;
            if (ox != OX_MAX) begin
              ox <= ox + 1'b1;
            end else begin
              ox <= '0;
              oy <= (oy != OY_MAX) ? oy + 1'b1 : '0;
            end
          end
        end
      end
    end
  end

  // Tag pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      tag_pad  <= 1'b0;
      tag_col  <= 1'b0;
      tag_frm  <= 1'b0;
    end else begin
      inflight <= issue;
      tag_pad  <= issue && !in_bounds;
      tag_col  <= issue && col_last;
      tag_frm  <= issue && frame_last;
    end
  end

  assign push_data = tag_pad ? '0 : bus.ram_dout;

  // Output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_d[i]  <= '0;
        fifo_cl[i] <= 1'b0;
        fifo_fl[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr]  <= push_data;
        fifo_cl[wr_ptr] <= tag_col;
        fifo_fl[wr_ptr] <= tag_frm;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.m_valid      = (count != 2'd0);
  assign bus.m_data       = bus.m_valid ? fifo_d[rd_ptr]  : '0;
  assign bus.m_col_last   = bus.m_valid ? fifo_cl[rd_ptr] : 1'b0;
  assign bus.m_frame_last = bus.m_valid ? fifo_fl[rd_ptr] : 1'b0;

endmodule
